button: RTL and testbench

Push-button conditioner: synchronizes a raw, bouncing mechanical switch input into the clock domain, debounces it with a stable-time filter, and produces one-cycle edge pulses. Sits between board-level push-button pins and control logic (counters, FSMs) that need a clean level and a single event per press or release. Default timing targets a 100 MHz clock with a 20 ms debounce window.

---
 rtl/button.sv | 112 +++++++++++
 tb/tb_button.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/button.sv
// Push-button conditioner: two-flop synchronizer, stable-time debounce FSM,
// and one-cycle edge pulses on each accepted level change.
module button #(
   parameter int STABLE_CYCLES = 2_000_000,
   parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic noisy,
   output logic debounced,
   output logic p_edge,
   output logic n_edge,
   output logic _edge
);

   typedef enum logic [1:0] {
      LOW       = 2'd0,
      WAIT_HIGH = 2'd1,
      HIGH      = 2'd2,
      WAIT_LOW  = 2'd3
   } state_t;

   // Terminal count: the candidate level has been held long enough
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic             sync1;
   logic             sync0;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             debounced_q;

   // Two-flop synchronizer; only sync0 is safe to use in this domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync0 <= 1'b0;
      end else begin
         sync1 <= noisy;
         sync0 <= sync1;
      end
   end

   // Debounce FSM: a new level must persist until the counter reaches its
   // terminal value; any reversal while waiting falls back to the old level.
   // The counter is always cleared on entry and held at the terminal value,
   // so it never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LOW;
         cnt       <= '0;
         debounced <= 1'b0;
      end else begin
         case (state)
            LOW: begin
               debounced <= 1'b0;
               if (sync0) begin
                  state <= WAIT_HIGH;
                  cnt   <= '0;
               end
            end
            WAIT_HIGH: begin
               if (!sync0) begin
                  // glitch: discard and stay low
                  state     <= LOW;
                  debounced <= 1'b0;
               end else if (cnt == CNT_MAX) begin
                  state     <= HIGH;
                  debounced <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HIGH: begin
               debounced <= 1'b1;
               if (!sync0) begin
                  state <= WAIT_LOW;
                  cnt   <= '0;
               end
            end
            WAIT_LOW: begin
               if (sync0) begin
                  state     <= HIGH;
                  debounced <= 1'b1;
               end else if (cnt == CNT_MAX) begin
                  state     <= LOW;
                  debounced <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               // unreachable encodings recover to the idle low state
               state     <= LOW;
               cnt       <= '0;
               debounced <= 1'b0;
            end
         endcase
      end
   end

   // Delayed copy of the filtered level for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) debounced_q <= 1'b0;
      else        debounced_q <= debounced;
   end

   // Pulses are decoded from two flops only, so they cannot glitch
   assign p_edge = debounced & ~debounced_q;
   assign n_edge = ~debounced & debounced_q;
   assign _edge  = debounced ^ debounced_q;

endmodule

// File: tb/tb_button.sv
// Bench for button: run-length reference model checked every cycle, plus
// directed press/release, bounce, boundary and mid-count reset scenarios.
module tb_button;

   localparam int S = 8;

   logic clk;
   logic rst_n;
   logic noisy;
   logic debounced;
   logic p_edge;
   logic n_edge;
   logic _edge;

   int n_cmp = 0;
   int n_err = 0;

   button #(.STABLE_CYCLES(S)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .noisy    (noisy),
      .debounced(debounced),
      .p_edge   (p_edge),
      .n_edge   (n_edge),
      ._edge    (_edge)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the filtered level flips once the synchronized input
   // has disagreed with it on S+1 consecutive clock edges.
   logic m_s1, m_s0, m_deb, m_deb_q;
   int   m_run;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 <= 1'b0; m_s0 <= 1'b0; m_deb <= 1'b0; m_deb_q <= 1'b0; m_run <= 0;
      end else begin
         m_s1    <= noisy;
         m_s0    <= m_s1;
         m_deb_q <= m_deb;
         if (m_s0 != m_deb) begin
            if (m_run == S) begin
               m_deb <= ~m_deb;
               m_run <= 0;
            end else begin
               m_run <= m_run + 1;
            end
         end else begin
            m_run <= 0;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      check("debounced", int'(debounced), int'(m_deb));
      check("p_edge", int'(p_edge), int'(m_deb & ~m_deb_q));
      check("n_edge", int'(n_edge), int'(~m_deb & m_deb_q));
      check("_edge", int'(_edge), int'(m_deb ^ m_deb_q));
   end

   // Running pulse totals for the directed count checks
   int p_tot = 0;
   int n_tot = 0;
   always @(negedge clk) begin
      if (p_edge) p_tot <= p_tot + 1;
      if (n_edge) n_tot <= n_tot + 1;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Count rising clock edges until debounced reaches lvl (bounded)
   task automatic measure(input string name, input logic lvl, input int exp_n);
      int n;
      n = 0;
      while (debounced !== lvl && n < 40) begin
         @(negedge clk);
         n++;
      end
      check(name, n, exp_n);
   endtask

   int p0, n0;

   initial begin
      noisy = 1'b0;
      rst_n = 1'b0;
      #2;
      check("reset debounced", int'(debounced), 0);
      check("reset _edge", int'(_edge), 0);
      rst_n = 1'b1;
      wait_cycles(3);
      check("post-reset debounced", int'(debounced), 0);

      // Clean press: noisy sampled on edge k, debounced rises on edge k+2+S
      noisy = 1'b1;
      measure("press latency", 1'b1, S + 3);
      check("press p_edge", int'(p_edge), 1);
      check("press _edge", int'(_edge), 1);
      wait_cycles(1);
      check("press p_edge width", int'(p_edge), 0);
      wait_cycles(20);

      // Clean release
      noisy = 1'b0;
      measure("release latency", 1'b0, S + 3);
      check("release n_edge", int'(n_edge), 1);
      wait_cycles(1);
      check("release n_edge width", int'(n_edge), 0);
      wait_cycles(20);

      // Five short toggles ending high: one rise, S+3 edges after last toggle
      p0 = p_tot; n0 = n_tot;
      repeat (4) begin
         noisy = ~noisy;
         wait_cycles(3);
      end
      noisy = ~noisy;
      measure("bounce latency", 1'b1, S + 3);
      wait_cycles(10);
      check("bounce p count", p_tot - p0, 1);
      check("bounce n count", n_tot - n0, 0);
      noisy = 1'b0;
      wait_cycles(25);

      // Six toggles returning low: nothing happens
      p0 = p_tot; n0 = n_tot;
      repeat (6) begin
         noisy = ~noisy;
         wait_cycles(3);
      end
      wait_cycles(25);
      check("even toggles p count", p_tot - p0, 0);
      check("even toggles n count", n_tot - n0, 0);

      // Boundary: 7-cycle pulse never reaches the terminal count
      p0 = p_tot;
      noisy = 1'b1; wait_cycles(S - 1);
      noisy = 1'b0; wait_cycles(20);
      check("pulse S-1 p count", p_tot - p0, 0);

      // Boundary: release arrives on the edge the counter hits S-1
      p0 = p_tot;
      noisy = 1'b1; wait_cycles(S);
      noisy = 1'b0; wait_cycles(20);
      check("pulse S reversal p count", p_tot - p0, 0);

      // One more cycle of hold is enough to be accepted
      p0 = p_tot; n0 = n_tot;
      noisy = 1'b1; wait_cycles(S + 1);
      noisy = 1'b0; wait_cycles(25);
      check("pulse S+1 p count", p_tot - p0, 1);
      check("pulse S+1 n count", n_tot - n0, 1);
      check("pulse S+1 final level", int'(debounced), 0);

      // Mid-count reset while waiting to go high, then a full restart
      noisy = 1'b1;
      wait_cycles(6);
      #2 rst_n = 1'b0;
      #1;
      check("midreset debounced", int'(debounced), 0);
      check("midreset p_edge", int'(p_edge), 0);
      #1 rst_n = 1'b1;
      measure("midreset restart latency", 1'b1, S + 3);
      check("midreset p_edge", int'(p_edge), 1);
      noisy = 1'b0;
      wait_cycles(25);
      check("final debounced", int'(debounced), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
